uart_rx_cmd: RTL
================

# uart_rx_cmd

UART receiver front end for the stopwatch/clock command path. It oversamples the serial `rx` line at 16x the baud rate and deserialises 8N1 frames, LSB first. Each received byte is presented to the downstream command decoder as a single-cycle byte on `cmd_data`, which reads 8'h00 at all other times. This makes each ASCII command (R/C/S/M/H/I) produce exactly one decoder pulse.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: serial bit rate.
- `OVS`, 16: oversampling ticks per bit. Fixed at 16; other values are not supported.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  last correctly framed byte; held until the next good frame.
- `rx_done`  output  1  one-cycle pulse when a good frame completes.
- `cmd_data`  output  8  equals the received byte during the `rx_done` cycle, 8'h00 otherwise.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples 0.

## Operation
- **Input synchroniser:** two flops on `rx`, both reset to 1. All FSM decisions use the second flop (`rx_s`).
- **Tick generator:** free-running counter from 0 to DIV-1, with DIV = CLK_FREQ/(BAUD*16), integer truncation (651 at the defaults). `tick` is high for one clk when the counter equals DIV-1. The counter resets to 0 and is never cleared by the FSM.
- **Counters:** 4-bit tick counter `tcnt` and 3-bit bit counter `bcnt`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HI. Reset state is IDLE.
  - **IDLE:** when `rx_s`==0, go to START and clear `tcnt`.
  - **START:** increment `tcnt` on each tick.
    - At the tick where `tcnt`==7 (mid start bit): if `rx_s`==0, go to DATA with `tcnt`=0 and `bcnt`=0.
    - Otherwise it was a glitch: go to IDLE with no output activity.
  - **DATA:** increment `tcnt` on each tick.
    - At the tick where `tcnt`==15, shift `rx_s` into the MSB of the shift register (right shift, so LSB-first arrives correctly) and set `tcnt`=0.
    - If `bcnt`==7, go to STOP; else increment `bcnt`.
  - **STOP:** at the tick where `tcnt`==15, sample `rx_s`.
    - If 1: `rx_data`<=shift register, `cmd_data`<=shift register, `rx_done`<=1, then go to IDLE.
    - If 0: `frame_err`<=1, `rx_data` unchanged, `cmd_data` stays 00, then go to WAIT_HI.
  - **WAIT_HI:** stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being parsed as frames.
- **Output clearing:** `rx_done`, `frame_err` and `cmd_data` clear automatically on the next clk.
- **Zero byte:** a received byte of 8'h00 still pulses `rx_done`. `cmd_data` stays 00, which the decoder ignores.

## Timing
- **Reset values:** `rx_data`=00, `cmd_data`=00, `rx_done`=0, `frame_err`=0, state IDLE, counters 0, shift register 0.
- **Reset mid-frame:** immediate return to IDLE with all outputs at reset values. No partial byte is ever emitted.
- **Output registration:** all outputs are registered. `rx_done`, `cmd_data` and `frame_err` assert in the clk after the tick on which the stop bit is sampled. Each is high or valid for exactly 1 clk.
- **Latency:** from the `rx` falling edge of the start bit to `rx_done` is 2 clk (synchroniser) + (8 + 9*16 = 152) ticks ±1 tick + 1 clk. That is about 9.5 bit times.
- **Back-to-back frames:** the FSM is back in IDLE mid stop bit. The next start edge is accepted with zero idle bits between frames.
- **Tolerance:** sampling at the tick nearest mid-bit gives roughly ±4% baud mismatch tolerance.
- **Simultaneous pulses:** `rx_done` and `frame_err` are never high in the same cycle.

## Test plan
Use `CLK_FREQ`=1_600_000, `BAUD`=10_000 (DIV=10, 160 clk per bit) for all scenarios.
- **Single frame:** send 0x52 ('R') with a valid stop bit -> exactly one `rx_done` pulse; `cmd_data`=0x52 for that single cycle and 0x00 otherwise; `rx_data`=0x52 afterwards; `frame_err` never high.
- **Glitch rejection:** drive `rx` low for 40 clk (4 ticks), then high -> no `rx_done`, no `frame_err`, FSM back in IDLE; a following 0x73 ('s') is received correctly.
- **Framing error:** send 0x4D with stop bit 0, hold `rx` low for 3 more bit times, then high -> one `frame_err` pulse, no `rx_done`, `rx_data` keeps its prior value, no further frames reported until `rx` goes high; a subsequent 0x68 is received correctly.
- **Back-to-back frames:** send 0x53, 0x6D, 0x43 with no idle bits -> three `rx_done` pulses in order, with `cmd_data` values 0x53, 0x6D, 0x43.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF, release, then send 0x49 -> all outputs 0 during reset, no byte from the aborted frame, and 0x49 received cleanly.
- **Baud skew:** send 0xA5 at +3% and −3% bit period -> `rx_data`=0xA5 and `rx_done` pulses once in each case.

Source files
------------

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 16x oversampling 8N1 UART receiver for the command path.
// Each good frame yields a one-cycle rx_done pulse and a one-cycle byte on
// cmd_data (00 otherwise); a low stop bit yields a one-cycle frame_err pulse.
module uart_rx_cmd #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic [7:0] cmd_data,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  logic          rx_m, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;

  state_t     state, state_nxt;
  logic [3:0] tcnt, tcnt_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] rx_data_nxt, cmd_data_nxt;
  logic       rx_done_nxt, frame_err_nxt;

  // Two-flop synchroniser on the asynchronous line; resets to the idle level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the second stage a real second flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running 16x baud tick divider; never cleared by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + DW'(1);
  end

  assign tick = (div_cnt == DIV_LAST);

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      cmd_data  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= rx_data_nxt;
      cmd_data  <= cmd_data_nxt;
      rx_done   <= rx_done_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Next-state and output decode; pulse outputs default low so they last one clk.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt     = state;
    tcnt_nxt      = tcnt;
    bcnt_nxt      = bcnt;
    shreg_nxt     = shreg;
    rx_data_nxt   = rx_data;
    cmd_data_nxt  = 8'h00;
    rx_done_nxt   = 1'b0;
    frame_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          tcnt_nxt  = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tcnt == 4'd7) begin
            // Mid start bit: still low means a real frame, otherwise a glitch.
            if (!rx_s) begin
              state_nxt = DATA;
              tcnt_nxt  = '0;
              bcnt_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tcnt == 4'd15) begin
            // Right shift: the first (LSB) bit ends up in bit 0 after eight.
            shreg_nxt = {rx_s, shreg[7:1]};
            tcnt_nxt  = '0;
            if (bcnt == 3'd7) state_nxt = STOP;
            else              bcnt_nxt  = bcnt + 3'd1;
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tcnt == 4'd15) begin
            if (rx_s) begin
              rx_data_nxt  = shreg;
              cmd_data_nxt = shreg;
              rx_done_nxt  = 1'b1;
              state_nxt    = IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_HI;
            end
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
      end

      WAIT_HI: begin
        // A held-low line (break) must not be parsed as a stream of frames.
        if (rx_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
